// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and helpers for the NN datapath FIFO.
package mem_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_EXTRA_BITS = 2;
  localparam int DEF_ADDRESS_WIDTH = 3;
  localparam int WORD_W = DEF_DATA_WIDTH + DEF_EXTRA_BITS;
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/mem_fifo_ram.sv
// mem_fifo_ram: unreset register array, one write port and one asynchronous read port.
module mem_fifo_ram #(
  parameter int WIDTH = 34,
  parameter int AW = 3
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [1<<AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_fifo.sv
// mem_fifo: parametrised synchronous FIFO with occupancy, threshold flags and sticky errors.
// Defining MEM_FIFO_FWFT_EN selects first-word-fall-through reads instead of a registered read.
module mem_fifo
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXTRA_BITS = DEF_EXTRA_BITS,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int AF_LEVEL = (1 << ADDRESS_WIDTH) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic [DATA_WIDTH+EXTRA_BITS-1:0] data_in,
  input  logic wr_en,
  input  logic rd_en,
  output logic [DATA_WIDTH+EXTRA_BITS-1:0] data_out,
  output logic data_valid,
  output logic full,
  output logic empty,
  output logic almost_full,
  output logic almost_empty,
  output logic [ADDRESS_WIDTH:0] count,
  output logic overflow,
  output logic underflow
);
  localparam int W = DATA_WIDTH + EXTRA_BITS;
  localparam int CW = count_width(ADDRESS_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDRESS_WIDTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] rdata;
  logic rd_ok, wr_ok;
  assign empty = count == '0;
  assign full = count == DEPTH_C;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign rd_ok = rd_en & !empty;
  assign wr_ok = wr_en & (!full | rd_ok);
  mem_fifo_ram #(.WIDTH(W), .AW(ADDRESS_WIDTH)) u_ram (
    .clk(clk),
    .we(wr_ok & !flush),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDRESS_WIDTH'(wr_ok);
      rd_ptr <= rd_ptr + ADDRESS_WIDTH'(rd_ok);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      overflow <= overflow | (wr_en & !wr_ok);
      underflow <= underflow | (rd_en & !rd_ok);
    end
`ifdef MEM_FIFO_FWFT_EN
  assign data_out = rdata;
  assign data_valid = !empty;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (rd_ok) data_out <= rdata;
    end
`endif
endmodule

// File: tb/tb_mem_fifo.sv
// tb_mem_fifo: randomized and directed checks of mem_fifo against a queue-based model.
module tb_mem_fifo;
  import mem_pkg::*;
  localparam int W = WORD_W;
  localparam int DEPTH = 8;
  logic clk = 0, rst_n = 0, flush = 0, wr_en = 0, rd_en = 0;
  logic [W-1:0] data_in = '0, data_out;
  logic data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout;
  bit exp_valid, exp_ov, exp_un;
  always #5 clk = ~clk;
  mem_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int n = q.size();
    check({tag, ":count"}, 64'(count), 64'(n));
    check({tag, ":full"}, 64'(full), 64'(n == DEPTH));
    check({tag, ":empty"}, 64'(empty), 64'(n == 0));
    check({tag, ":almost_full"}, 64'(almost_full), 64'(n >= DEPTH - 1));
    check({tag, ":almost_empty"}, 64'(almost_empty), 64'(n <= 1));
    check({tag, ":overflow"}, 64'(overflow), 64'(exp_ov));
    check({tag, ":underflow"}, 64'(underflow), 64'(exp_un));
`ifdef MEM_FIFO_FWFT_EN
    check({tag, ":data_valid"}, 64'(data_valid), 64'(n > 0));
    if (n > 0) check({tag, ":data_out"}, 64'(data_out), 64'(q[0]));
`else
    check({tag, ":data_valid"}, 64'(data_valid), 64'(exp_valid));
    check({tag, ":data_out"}, 64'(data_out), 64'(exp_dout));
`endif
  endtask
  function automatic void model_reset();
    q.delete();
    exp_dout = '0;
    exp_valid = 0;
    exp_ov = 0;
    exp_un = 0;
  endfunction
  task automatic step(input bit w, input bit r, input bit f, input logic [W-1:0] d, input string tag);
    bit rok, wok;
    wr_en = w;
    rd_en = r;
    flush = f;
    data_in = d;
    @(posedge clk);
    if (f) begin
      q.delete();
      exp_ov = 0;
      exp_un = 0;
      exp_valid = 0;
    end else begin
      rok = r && q.size() > 0;
      wok = w && (q.size() < DEPTH || rok);
      exp_ov |= w && !wok;
      exp_un |= r && !rok;
      exp_valid = rok;
      if (rok) exp_dout = q.pop_front();
      if (wok) q.push_back(d);
    end
    #1;
    wr_en = 0;
    rd_en = 0;
    flush = 0;
    check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    model_reset();
    #1 check_all(tag);
    #3 rst_n = 1;
  endtask
  initial begin
    model_reset();
    #2 check_all("reset");
    #10 rst_n = 1;
    for (int i = 1; i <= 8; i++) step(1, 0, 0, W'(i), "fill");
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0, "drain");
    step(0, 1, 0, '0, "underflow_rd");
    step(1, 1, 0, W'(34'h55), "empty_wr_rd");
    step(0, 0, 1, '0, "flush1");
    for (int i = 1; i <= 8; i++) step(1, 0, 0, W'(i + 16), "refill");
    step(1, 0, 0, W'(34'h3_DEADBEEF), "overflow");
    step(1, 1, 0, W'(34'hA), "full_wr_rd");
    for (int i = 0; i < 9; i++) step(0, 1, 0, '0, "drain2");
    step(0, 0, 1, '0, "flush2");
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step(1, 0, 0, W'(100 + 3 * k + i), "wrap_wr");
      for (int i = 0; i < 3; i++) step(0, 1, 0, '0, "wrap_rd");
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, W'(200 + i), "pre_flush");
    step(0, 1, 0, '0, "pre_flush_rd");
    step(0, 0, 0, '0, "pre_flush_idle");
    step(1, 1, 1, W'(34'h77), "flush_prio");
    for (int i = 0; i < 3; i++) step(1, 0, 0, W'(300 + i), "burst");
    async_reset("async_reset");
    step(1, 0, 0, W'(34'h1_2345), "post_reset_wr");
    step(0, 1, 0, '0, "post_reset_rd");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom_range(0, 99) == 0,
           W'({$urandom, $urandom}), "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
